// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder.
// Port ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, ci,
        input  busy, done, sum, co
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, sum, co
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one result bit per clock, LSB first; IDLE -> RUN -> DONE.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow flag.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q, co_q;
    logic [WIDTH-1:0] sum_q;
    logic             s, c_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    assign s      = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            co_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.ci;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {s, res_sh[WIDTH-1:1]};
                    carry  <= c_next;
                    cnt    <= cnt + 1'b1;
                    // Last bit: publish the result including the bit being produced now.
                    if (cnt == LAST) begin
                        sum_q  <= {s, res_sh[WIDTH-1:1]};
                        co_q   <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q  <= carry ^ c_next;
`endif
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = ref_add(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else passed++;
    endtask

    // Runs one addition; poke>=0 re-asserts start with a=0xAA at that cycle offset.
    task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci, input int poke,
                          output logic [W-1:0] rs, output logic rco, output logic rovf,
                          output int lat, output int busy_cyc, output bit stable,
                          output logic busy_at_done, output logic done_after);
        logic [W-1:0] s0;
        logic         c0;
        s0 = bus.sum; c0 = bus.co; stable = 1'b1;
        bus.a = ta; bus.b = tb_; bus.ci = tci; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.ci = 1'($urandom);
        lat = 0; busy_cyc = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.sum !== s0 || bus.co !== c0) stable = 1'b0;
            if (lat == poke) begin bus.start = 1'b1; bus.a = 8'hAA; end
            else bus.start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        rs = bus.sum; rco = bus.co; busy_at_done = bus.busy;
`ifdef SERIAL_ADDER_OVF_EN
        rovf = bus.ovf;
`else
        rovf = 1'b0;
`endif
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_sum", bus.sum, 0);
        chk("reset_co", bus.co, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_ovf", bus.ovf, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vector(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci);
        logic [W-1:0] rs; logic rco, rovf, bad, da; int lat, bc; bit st;
        logic [W:0] e;
        e = ref_add(ta, tb_, tci);
        do_add(ta, tb_, tci, -1, rs, rco, rovf, lat, bc, st, bad, da);
        chk({name, "_sum"}, rs, e[W-1:0]);
        chk({name, "_co"}, rco, e[W]);
        chk({name, "_latency"}, lat, W);
        chk({name, "_busy_cycles"}, bc, W);
        chk({name, "_busy_in_done"}, bad, 0);
        chk({name, "_done_one_cycle"}, da, 0);
        chk({name, "_stable"}, st, 1);
`ifdef SERIAL_ADDER_OVF_EN
        chk({name, "_ovf"}, rovf, ref_ovf(ta, tb_, tci));
`endif
    endtask

    task automatic test_start_ignored();
        logic [W-1:0] rs; logic rco, rovf, bad, da; int lat, bc; bit st;
        do_add(8'h0F, 8'h01, 1'b0, 2, rs, rco, rovf, lat, bc, st, bad, da);
        chk("restart_sum", rs, 8'h10);
        chk("restart_co", rco, 0);
        chk("restart_latency", lat, W);
        // A second accepted start would show up as busy right after DONE.
        chk("restart_no_second_op", bus.busy, 0);
    endtask

    task automatic test_mid_reset();
        bit pulsed;
        bus.a = 8'h55; bus.b = 8'hAB; bus.ci = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_co", bus.co, 0);
        pulsed = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulsed = 1'b1;
        end
        chk("midrst_no_done", pulsed, 0);
        test_vector("after_rst", 8'h12, 8'h34, 1'b1);
    endtask

    task automatic test_rst_priority();
        bus.a = 8'h01; bus.b = 8'h01; bus.ci = 1'b0; bus.start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_over_start_busy", bus.busy, 0);
        @(posedge clk); #1;
        chk("rst_over_start_idle", bus.busy, 0);
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb_, rs; logic tci, rco, rovf, bad, da; int lat, bc; bit st;
        logic [W:0] e;
        for (int i = 0; i < 1000; i++) begin
            ta = W'($urandom); tb_ = W'($urandom); tci = 1'($urandom);
            e = ref_add(ta, tb_, tci);
            do_add(ta, tb_, tci, -1, rs, rco, rovf, lat, bc, st, bad, da);
            chk("rand_result", {rco, rs}, e);
            chk("rand_stable_timing", {st, lat[7:0], da}, {1'b1, 8'(W), 1'b0});
`ifdef SERIAL_ADDER_OVF_EN
            chk("rand_ovf", rovf, ref_ovf(ta, tb_, tci));
`endif
        end
    endtask

    initial begin
        test_reset();
        test_vector("zero", 8'h00, 8'h00, 1'b0);
        test_vector("wrap", 8'hFF, 8'h01, 1'b0);
        test_vector("max", 8'hFF, 8'hFF, 1'b1);
        test_vector("sovf", 8'h7F, 8'h01, 1'b0);
        test_start_ignored();
        test_mid_reset();
        test_rst_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
